// File: rtl/ow_slave_responder.sv
// ow_slave_responder
//   1-Wire slave endpoint. It detects the master's reset pulse and answers with
//   a presence pulse. It then takes an 8-bit ROM command and serves READ ROM
//   (0x33), SKIP ROM (0xCC) or MATCH ROM (0x55). After the device is selected
//   it captures a DATA_BITS word from the master.
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   bus          1-Wire line; only ever driven 0 or released (z)
//   rom_id       device ROM code, LSB first on the bus
//   cmd          last ROM command received
//   data_out     received data word, LSB = first bit on the bus
//   data_valid   1-cycle pulse when data_out updates
//   rom_matched  device selected since the last bus reset
module ow_slave_responder #(
  parameter int T_RST_MIN = 480,
  parameter int T_PDH     = 30,
  parameter int T_PDL     = 120,
  parameter int T_SAMPLE  = 30,
  parameter int T_HOLD    = 45,
  parameter int DATA_BITS = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  inout  wire                  bus,
  input  logic [63:0]          rom_id,
  output logic [7:0]           cmd,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 rom_matched
);
  localparam int SRW = (DATA_BITS > 64) ? DATA_BITS : 64;
  localparam int BCW = $clog2(SRW) + 1;
  localparam int LW  = $clog2(T_RST_MIN + 1);
  localparam int TW  = $clog2(T_PDH + T_PDL + 1);
  localparam int SW  = $clog2(T_SAMPLE + T_HOLD + 1);

  typedef enum logic [2:0] {
    IDLE, PRES_WAIT, PRES_DRV, CMD_RX, ROM_TX, MATCH_RX, DATA_RX
  } state_t;

  state_t          state, state_n;
  logic            bus_s1, bus_s, bus_q;
  logic            drive_low;
  logic [LW-1:0]   low_cnt;
  logic [TW-1:0]   t_cnt;
  logic [SW-1:0]   slot_cnt;
  logic            slot_active;
  logic [BCW-1:0]  bit_cnt;
  logic [SRW-1:0]  sr, sr_n;
  logic            rst_det, slot_start, slot_state, rx_state;
  logic            sample, hold_end, cmd_done, match_done, data_done, match_ok;
  logic [7:0]      cmd_byte;

  assign bus = drive_low ? 1'b0 : 1'bz;

  // Rising edge after a long enough low is a master reset, from any state.
  assign rst_det    = bus_s & ~bus_q & (low_cnt == LW'(T_RST_MIN));
  // Our own falling edges arrive while drive_low is still set, so they never start a slot.
  assign slot_start = bus_q & ~bus_s & ~drive_low;
  assign slot_state = (state == CMD_RX) || (state == ROM_TX) ||
                      (state == MATCH_RX) || (state == DATA_RX);
  assign rx_state   = (state == CMD_RX) || (state == MATCH_RX) || (state == DATA_RX);
  assign sample     = rx_state && slot_active && (slot_cnt == SW'(T_SAMPLE));
  assign hold_end   = (state == ROM_TX) && slot_active && (slot_cnt == SW'(T_HOLD - 1));
  assign sr_n       = {bus_s, sr[SRW-1:1]};
  assign cmd_byte   = sr_n[SRW-1 -: 8];
  assign match_ok   = (sr_n[SRW-1 -: 64] == rom_id);
  assign cmd_done   = (state == CMD_RX)   && sample && (bit_cnt == BCW'(7));
  assign match_done = (state == MATCH_RX) && sample && (bit_cnt == BCW'(63));
  assign data_done  = (state == DATA_RX)  && sample && (bit_cnt == BCW'(DATA_BITS - 1));

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_n;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      ;
      PRES_WAIT: if (t_cnt == TW'(T_PDH - 1)) state_n = PRES_DRV;
      PRES_DRV:  if (t_cnt == TW'(T_PDL) && bus_s) state_n = CMD_RX;
      CMD_RX:    if (cmd_done) begin
                   case (cmd_byte)
                     8'h33:   state_n = ROM_TX;
                     8'hCC:   state_n = DATA_RX;
                     8'h55:   state_n = MATCH_RX;
                     default: state_n = IDLE;
                   endcase
                 end
      ROM_TX:    if (hold_end && bit_cnt == BCW'(63)) state_n = DATA_RX;
      MATCH_RX:  if (match_done) state_n = match_ok ? DATA_RX : IDLE;
      DATA_RX:   if (data_done) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
    if (rst_det) state_n = PRES_WAIT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_s1 <= 1'b1; bus_s <= 1'b1; bus_q <= 1'b1;
      drive_low <= 1'b0; low_cnt <= '0; t_cnt <= '0;
      slot_cnt <= '0; slot_active <= 1'b0; bit_cnt <= '0; sr <= '0;
      cmd <= '0; data_out <= '0; data_valid <= 1'b0; rom_matched <= 1'b0;
    end else begin
      bus_s1     <= bus;
      bus_s      <= bus_s1;
      bus_q      <= bus_s;
      low_cnt    <= bus_s ? '0 : ((low_cnt == LW'(T_RST_MIN)) ? low_cnt : low_cnt + 1'b1);
      data_valid <= 1'b0;
      if (rst_det) begin
        drive_low   <= 1'b0;
        slot_active <= 1'b0;
        slot_cnt    <= '0;
        bit_cnt     <= '0;
        sr          <= '0;
        rom_matched <= 1'b0;
        // The detection cycle is already the first bus-high cycle of the wait.
        t_cnt       <= TW'(1);
      end else begin
        if (slot_start && slot_state && !slot_active) begin
          slot_active <= 1'b1;
          slot_cnt    <= '0;
          if (state == ROM_TX) drive_low <= ~rom_id[bit_cnt[5:0]];
        end else if (slot_active) begin
          slot_cnt <= slot_cnt + 1'b1;
        end
        if (sample) begin
          sr          <= sr_n;
          bit_cnt     <= bit_cnt + 1'b1;
          slot_active <= 1'b0;
        end
        if (hold_end) begin
          drive_low   <= 1'b0;
          slot_active <= 1'b0;
          bit_cnt     <= bit_cnt + 1'b1;
        end
        case (state)
          PRES_WAIT: begin
            t_cnt <= t_cnt + 1'b1;
            if (state_n == PRES_DRV) begin
              t_cnt     <= '0;
              drive_low <= 1'b1;
            end
          end
          PRES_DRV: begin
            if (t_cnt != TW'(T_PDL)) t_cnt <= t_cnt + 1'b1;
            if (t_cnt == TW'(T_PDL - 1)) drive_low <= 1'b0;
          end
          default: ;
        endcase
        // Each phase counts its own bits from zero.
        if (state_n != state) bit_cnt <= '0;
        if (cmd_done) begin
          cmd <= cmd_byte;
          if (cmd_byte == 8'h33 || cmd_byte == 8'hCC) rom_matched <= 1'b1;
        end
        if (match_done && match_ok) rom_matched <= 1'b1;
        if (data_done) begin
          data_out   <= sr_n[SRW-1 -: DATA_BITS];
          data_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ow_slave_responder.sv
// Directed bench for ow_slave_responder: acts as the 1-Wire master and
// checks presence timing, ROM read-out, data capture and match rejection.
module tb_ow_slave_responder;
  localparam logic [63:0] ROM = 64'hA5C3_0F01_2345_6789;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m_low = 1'b0;
  logic [63:0] rom_id = ROM;
  logic [7:0]  cmd;
  logic [63:0] data_out;
  logic        data_valid, rom_matched;
  wire         bus;
  int          checks = 0, errors = 0, dv_total = 0;

  assign bus = m_low ? 1'b0 : 1'bz;
  pullup (bus);

  always #5 clk = ~clk;
  always @(negedge clk) if (data_valid === 1'b1) dv_total++;

  ow_slave_responder dut (
    .clk(clk), .reset(reset), .bus(bus), .rom_id(rom_id), .cmd(cmd),
    .data_out(data_out), .data_valid(data_valid), .rom_matched(rom_matched)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // 480-cycle reset pulse, then measure delay to presence and its length.
  task automatic bus_reset(input string tag);
    int start, len;
    m_low = 1'b1; tick(480); m_low = 1'b0;
    start = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (bus === 1'b0) begin start = k; break; end
    end
    len = 0;
    if (start != 0) begin
      len = 1;
      for (int k = 0; k < 300; k++) begin
        tick();
        if (bus !== 1'b0) break;
        len++;
      end
    end
    checks++;
    if (start != 32) begin errors++; $display("FAIL %s presence_start got %0d want 32", tag, start); end
    checks++;
    if (len != 120) begin errors++; $display("FAIL %s presence_len got %0d want 120", tag, len); end
    tick(10);
  endtask

  task automatic write_bit(input logic b);
    m_low = 1'b1; tick(b ? 5 : 60);
    m_low = 1'b0; tick(b ? 70 : 15);
  endtask

  task automatic write_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) write_bit(v[i]);
  endtask

  task automatic write_word(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) write_bit(v[i]);
  endtask

  task automatic test_reset;
    reset = 1'b0; tick(3);
    checks++;
    if ({bus, cmd, data_out, data_valid, rom_matched} !== {1'b1, 8'h0, 64'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got bus=%b cmd=%h data=%h dv=%b rm=%b want 1 00 0 0 0",
               bus, cmd, data_out, data_valid, rom_matched);
    end
    reset = 1'b1; tick(5);
  endtask

  task automatic test_short_low;
    int lows = 0;
    m_low = 1'b1; tick(300); m_low = 1'b0;
    for (int k = 0; k < 250; k++) begin tick(); if (bus === 1'b0) lows++; end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL short_low bus_low_cycles got %0d want 0", lows); end
    checks++;
    if (rom_matched !== 1'b0) begin errors++; $display("FAIL short_low rom_matched got %b want 0", rom_matched); end
  endtask

  task automatic test_presence;
    bus_reset("presence");
  endtask

  task automatic test_read_rom;
    logic [63:0] rd = '0;
    int bad = 0;
    write_byte(8'h33);
    checks++;
    if (cmd !== 8'h33 || rom_matched !== 1'b1) begin
      errors++; $display("FAIL read_rom_cmd got cmd=%h rm=%b want 33 1", cmd, rom_matched);
    end
    for (int i = 0; i < 64; i++) begin
      m_low = 1'b1; tick(5); m_low = 1'b0;
      for (int o = 6; o <= 75; o++) begin
        tick();
        if (o == 15) rd[i] = bus;
        if (o == 44 && bus !== ROM[i]) bad++;
        if (o == 55 && bus !== 1'b1) bad++;
      end
    end
    checks++;
    if (rd !== ROM) begin errors++; $display("FAIL read_rom_bits got %h want %h", rd, ROM); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL read_rom_hold bad_samples got %0d want 0", bad); end
  endtask

  task automatic test_skip_rom(input logic [63:0] w, input string tag);
    int dv0;
    write_byte(8'hCC);
    dv0 = dv_total;
    write_word(w, 64);
    checks++;
    if (data_out !== w) begin errors++; $display("FAIL %s data_out got %h want %h", tag, data_out, w); end
    checks++;
    if (dv_total - dv0 != 1) begin errors++; $display("FAIL %s data_valid_pulses got %0d want 1", tag, dv_total - dv0); end
    checks++;
    if (cmd !== 8'hCC || rom_matched !== 1'b1) begin
      errors++; $display("FAIL %s cmd_rm got cmd=%h rm=%b want cc 1", tag, cmd, rom_matched);
    end
  endtask

  // Async reset while the slave is holding the bus low for a 0 bit.
  task automatic test_async_reset;
    bus_reset("async_pre");
    write_byte(8'h33);
    m_low = 1'b1; tick(5); m_low = 1'b0; tick(70);   // bit 0 = 1
    m_low = 1'b1; tick(5); m_low = 1'b0; tick(10);   // bit 1 = 0
    checks++;
    if (bus !== 1'b0) begin errors++; $display("FAIL async_hold bus got %b want 0", bus); end
    reset = 1'b0; #1;
    checks++;
    if ({bus, cmd, data_out, data_valid, rom_matched} !== {1'b1, 8'h0, 64'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got bus=%b cmd=%h data=%h dv=%b rm=%b want 1 00 0 0 0",
               bus, cmd, data_out, data_valid, rom_matched);
    end
    tick(3); reset = 1'b1; tick(5);
  endtask

  task automatic test_match_fail;
    int dv0 = dv_total;
    logic [63:0] keep = data_out;
    bus_reset("match");
    write_byte(8'h55);
    write_word(ROM ^ 64'h20, 64);
    checks++;
    if (rom_matched !== 1'b0 || cmd !== 8'h55) begin
      errors++; $display("FAIL match_fail got rm=%b cmd=%h want 0 55", rom_matched, cmd);
    end
    write_word(64'hFFFF_0000_FFFF_0000, 64);
    checks++;
    if (dv_total != dv0 || data_out !== keep) begin
      errors++; $display("FAIL match_ignored got dv=%0d data=%h want 0 %h", dv_total - dv0, data_out, keep);
    end
  endtask

  task automatic test_mid_reset;
    logic [63:0] keep;
    bus_reset("mid_a");
    test_skip_rom(64'hDEAD_BEEF_0123_4567, "mid_first");
    keep = data_out;
    bus_reset("mid_b");
    write_byte(8'hCC);
    write_word(64'h0F0F_F0F0_5555_AAAA, 20);
    bus_reset("mid_c");
    checks++;
    if (data_out !== keep) begin errors++; $display("FAIL mid_reset data_out got %h want %h", data_out, keep); end
    test_skip_rom(64'h0123_4567_89AB_CDEF, "mid_next");
  endtask

  initial begin
    test_reset;
    test_short_low;
    test_presence;
    test_read_rom;
    test_presence;
    test_skip_rom(64'hDEAD_BEEF_0123_4567, "skip_rom");
    test_async_reset;
    test_match_fail;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
